// File: rtl/outer_out_downsizer_pkg.sv
// Shared bus widths and half-word selection helper for the outer-out
// downsizer and its FIFO.
package outer_out_downsizer_pkg;

  localparam int OUTER_BUS_W  = 64;
  localparam int OUTER_HALF_W = 32;

  function automatic logic [OUTER_HALF_W-1:0] pick_half(
    input logic [OUTER_BUS_W-1:0] word,
    input logic                   upper
  );
    return upper ? word[OUTER_BUS_W-1:OUTER_HALF_W] : word[OUTER_HALF_W-1:0];
  endfunction

endpackage

// File: rtl/outer_out_downsizer_bus_fifo_reg.sv
// Register-based FIFO with an isReady/canReceive handshake on both ports.
// Its full flag comes from registered occupancy only.
module bus_fifo_reg #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i,
  input  logic         i_isReady,
  output logic         i_canReceive,
  output logic [W-1:0] o,
  output logic         o_isReady,
  input  logic         o_canReceive,
  output logic         empty
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign i_canReceive = (count_q != FULL_CNT);
  assign o_isReady    = (count_q != '0);
  assign empty        = (count_q == '0);
  assign o            = mem_q[rd_ptr_q];
  assign push         = i_isReady && i_canReceive;
  assign pop          = o_isReady && o_canReceive;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/outer_out_downsizer.sv
// Buffers the adapter's 64-bit stream and emits it as 32-bit half-words,
// with a wrapping transfer counter and an idle flag for drain checks.
module outer_out_downsizer
  import outer_out_downsizer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LOW_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OUTER_BUS_W-1:0]  i,
  input  logic                    i_isReady,
  output logic                    i_canReceive,
  output logic [OUTER_HALF_W-1:0] o,
  output logic                    o_isReady,
  input  logic                    o_canReceive,
  output logic [CNT_W-1:0]        sent_count,
  output logic                    idle
);

  logic [OUTER_BUS_W-1:0] head;
  logic                   fifo_can_receive;
  logic                   fifo_valid;
  logic                   fifo_empty;
  logic                   half_q, half_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   xfer;
  logic                   upper;

  // The head entry is popped only when its second half is taken.
  bus_fifo_reg #(
    .W     (OUTER_BUS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i            (i),
    .i_isReady    (i_isReady),
    .i_canReceive (fifo_can_receive),
    .o            (head),
    .o_isReady    (fifo_valid),
    .o_canReceive (o_canReceive && half_q),
    .empty        (fifo_empty)
  );

  assign xfer  = fifo_valid && o_canReceive;
  assign upper = (LOW_FIRST == 0) ? !half_q : half_q;

  always_comb begin
    half_d = half_q;
    cnt_d  = cnt_q;
    if (xfer) begin
      half_d = !half_q;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      half_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      half_q <= half_d;
      cnt_q  <= cnt_d;
    end
  end

  // Outputs are forced to their reset values for as long as rst is held low.
  assign i_canReceive = rst && fifo_can_receive;
  assign o_isReady    = rst && fifo_valid;
  assign o            = o_isReady ? pick_half(head, upper) : '0;
  assign sent_count   = rst ? cnt_q : '0;
  assign idle         = !rst || fifo_empty;

endmodule

// File: tb/tb_outer_out_downsizer.sv
// Randomized self-checking bench: two downsizer instances share stimulus,
// one with default parameters and one high-half-first with a 4-bit counter.
module tb_outer_out_downsizer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i;
  logic        i_isReady;
  logic        o_canReceive;

  logic        a_i_canReceive, a_o_isReady, a_idle;
  logic [31:0] a_o;
  logic [15:0] a_sent_count;
  logic        b_i_canReceive, b_o_isReady, b_idle;
  logic [31:0] b_o;
  logic [3:0]  b_sent_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [63:0] src_q[$];
  int          model_cnt = 0;

  always #5 clk = ~clk;

  outer_out_downsizer #(.DEPTH(DEPTH), .LOW_FIRST(1), .CNT_W(16)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .i            (i),
    .i_isReady    (i_isReady),
    .i_canReceive (a_i_canReceive),
    .o            (a_o),
    .o_isReady    (a_o_isReady),
    .o_canReceive (o_canReceive),
    .sent_count   (a_sent_count),
    .idle         (a_idle)
  );

  outer_out_downsizer #(.DEPTH(DEPTH), .LOW_FIRST(0), .CNT_W(4)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .i            (i),
    .i_isReady    (i_isReady),
    .i_canReceive (b_i_canReceive),
    .o            (b_o),
    .o_isReady    (b_o_isReady),
    .o_canReceive (o_canReceive),
    .sent_count   (b_sent_count),
    .idle         (b_idle)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check against the model mid-cycle, then
  // advance the model on the edge. The source presents the head of src_q.
  task automatic applyStimulus(input logic rst_n, input logic want_valid, input logic sink);
    int          words;
    logic        exp_in, exp_ov, exp_idle;
    logic [31:0] exp_oa, exp_ob;
    logic [63:0] w;
    rst          = rst_n;
    i_isReady    = want_valid && (src_q.size() > 0);
    i            = (src_q.size() > 0) ? src_q[0] : 64'h0;
    o_canReceive = sink;
    @(negedge clk);
    words    = (qa.size() + 1) / 2;
    exp_in   = rst_n && (words < DEPTH);
    exp_ov   = rst_n && (qa.size() != 0);
    exp_oa   = exp_ov ? qa[0] : 32'h0;
    exp_ob   = exp_ov ? qb[0] : 32'h0;
    exp_idle = !rst_n || (qa.size() == 0);
    checkOutput("a_i_canReceive", a_i_canReceive, exp_in);
    checkOutput("a_o_isReady", a_o_isReady, exp_ov);
    checkOutput("a_o", a_o, exp_oa);
    checkOutput("a_idle", a_idle, exp_idle);
    checkOutput("a_sent_count", a_sent_count, rst_n ? 16'(model_cnt) : 16'h0);
    checkOutput("b_i_canReceive", b_i_canReceive, exp_in);
    checkOutput("b_o_isReady", b_o_isReady, exp_ov);
    checkOutput("b_o", b_o, exp_ob);
    checkOutput("b_idle", b_idle, exp_idle);
    checkOutput("b_sent_count", b_sent_count, rst_n ? 4'(model_cnt) : 4'h0);
    @(posedge clk);
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      model_cnt = 0;
    end else begin
      if (exp_ov && sink) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
        model_cnt++;
      end
      if (i_isReady && exp_in) begin
        w = src_q.pop_front();
        qa.push_back(w[31:0]);
        qa.push_back(w[63:32]);
        qb.push_back(w[63:32]);
        qb.push_back(w[31:0]);
      end
    end
    #1;
  endtask

  task automatic drainAll(input string tag);
    int guard = 0;
    while ((src_q.size() > 0 || qa.size() > 0) && guard < 5000) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      guard++;
    end
    checkOutput(tag, guard < 5000, 1'b1);
  endtask

  initial begin
    int guard;
    rst          = 1'b0;
    i            = '0;
    i_isReady    = 1'b0;
    o_canReceive = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    // Single word, no backpressure.
    src_q.push_back(64'h1111_2222_3333_4444);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("single_o_first", a_o, 32'h3333_4444);
    checkOutput("single_b_first", b_o, 32'h1111_2222);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("single_count", a_sent_count, 16'd2);
    checkOutput("single_idle", a_idle, 1'b1);

    // Fill to full with the sink stalled, then drain.
    for (int k = 0; k < 5; k++) src_q.push_back({$urandom, $urandom});
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("full_can_receive", a_i_canReceive, 1'b0);
    checkOutput("full_held", src_q.size(), 1);
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("full_drained_idle", a_idle, 1'b1);
    checkOutput("full_drained_count", a_sent_count, 16'd10);
    drainAll("fifth_drain_timeout");

    // Random valid and backpressure over 200 words.
    for (int k = 0; k < 200; k++) src_q.push_back({$urandom, $urandom});
    guard = 0;
    while (src_q.size() > 0 && guard < 5000) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      guard++;
    end
    checkOutput("random_timeout", guard < 5000, 1'b1);
    drainAll("random_drain_timeout");
    checkOutput("random_count_a", a_sent_count, 16'd412);
    checkOutput("random_count_b", b_sent_count, 4'd12);

    // Reset mid-stream with half-select set.
    for (int k = 0; k < 3; k++) src_q.push_back({$urandom, $urandom});
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_o_isReady", a_o_isReady, 1'b0);
    checkOutput("rst_count", a_sent_count, 16'd0);
    checkOutput("rst_idle", a_idle, 1'b1);
    src_q.push_back(64'h5555_6666_7777_8888);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("rst_first_half_a", a_o, 32'h7777_8888);
    checkOutput("rst_first_half_b", b_o, 32'h5555_6666);
    drainAll("rst_drain_timeout");

    // Counter wrap on the 4-bit instance: 9 words is 18 transfers.
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) src_q.push_back({$urandom, $urandom});
    drainAll("wrap_drain_timeout");
    checkOutput("wrap_count_b", b_sent_count, 4'd2);
    checkOutput("wrap_count_a", a_sent_count, 16'd18);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
